// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// Existing 4-bit ripple-carry adder slice (module rca4), reused every cycle by the serial adder.
module rca4 (
    input  logic [3:0] _a,
    input  logic [3:0] _b,
    input  logic       _cin,
    output logic [3:0] _s,
    output logic       _cout
);

    assign {_cout, _s} = 5'(_a) + 5'(_b) + 5'(_cin);

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one rca4 slice per clock, carry kept in a register between slices.
// Optional signed-overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         _clk,
    input  logic                         _rst,
    input  logic                         _start,
    input  logic [NIBBLE_W*NIBBLES-1:0]  _a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  _b,
    input  logic                         _cin,
    output logic                         _busy,
    output logic                         _done,
    output logic [NIBBLE_W*NIBBLES-1:0]  _s,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic                         _ovf,
`endif
    output logic                         _cout
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

    state_t           state_q, state_d;
    nib_vec_t         a_q, a_d;
    nib_vec_t         b_q, b_d;
    nib_vec_t         s_q, s_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;
    logic                accept;

    // Slice mux: the current nibble of each latched operand feeds the shared adder.
    assign slice_a = a_q[idx_q];
    assign slice_b = b_q[idx_q];

    rca4 _rca4 (
        ._a    (slice_a),
        ._b    (slice_b),
        ._cin  (carry_q),
        ._s    (slice_s),
        ._cout (slice_cout)
    );

    assign accept = _start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state and next-register values.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_ADD: begin
                s_d[idx_q] = slice_s;
                carry_d    = slice_cout;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    cout_d  = slice_cout;
                    // Carry into the MSB recovered from the top-nibble MSB bits.
                    ovf_d   = slice_a[NIBBLE_W-1] ^ slice_b[NIBBLE_W-1]
                            ^ slice_s[NIBBLE_W-1] ^ slice_cout;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Accept overrides: valid from IDLE and DONE for back-to-back operation.
        if (accept) begin
            state_d = ST_ADD;
            a_d     = _a;
            b_d     = _b;
            carry_d = _cin;
            s_d     = '0;
            idx_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge _clk or posedge _rst) begin
        if (_rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign _busy = busy_q;
    assign _done = done_q;
    assign _s    = s_q;
    assign _cout = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign _ovf  = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: arithmetic reference model plus directed cases.
module tb_nibble_serial_adder;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;
    localparam int          TMO     = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] s;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        ._clk   (clk),
        ._rst   (rst),
        ._start (start),
        ._a     (a),
        ._b     (b),
        ._cin   (cin),
        ._busy  (busy),
        ._done  (done),
        ._s     (s),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ._ovf   (ovf),
`endif
        ._cout  (cout)
    );

`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: full sum computed at accept; progress is just "nibbles completed".
    bit         m_active;
    int         m_cnt;
    logic [W:0] m_sum;
    bit         m_done;
    bit         m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_cnt = 0; m_sum = '0; m_done = 0; m_ovf = 0;
        end else begin
            bit acc;
            logic [W+1:0] t;
            acc    = start && !m_active;
            m_done = 0;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == NIBBLES) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
            if (acc) begin
                m_sum    = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
                t        = {a[W-1], a[W-1], a} + {b[W-1], b[W-1], b} + (W+2)'(cin);
                m_ovf    = t[W] ^ t[W-1];
                m_active = 1;
                m_cnt    = 0;
                m_done   = 0;
            end
        end
    end

    function automatic logic [W-1:0] exp_s();
        logic [W-1:0] one;
        one = W'(1);
        if (m_cnt == 0) return '0;
        return m_sum[W-1:0] & ((one << (4 * m_cnt)) - one);
    endfunction

    function automatic logic exp_final(input logic v);
        return (!m_active && m_cnt == NIBBLES) ? v : 1'b0;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 64'(busy), 64'(m_active));
            check("done", 64'(done), 64'(m_done));
            check("sum",  64'(s),    64'(exp_s()));
            check("cout", 64'(cout), 64'(exp_final(m_sum[W])));
            check("busy_done_excl", 64'(busy & done), 64'(0));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            check("ovf", 64'(ovf), 64'(exp_final(m_ovf)));
`endif
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n == TMO) check("idle_timeout", 64'(1), 64'(0));
    endtask

    // Returns cycles from the negedge after the accept edge until done is seen.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < TMO) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic [W-1:0] es, input logic ec, input string name);
        int n;
        wait_idle();
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        wait_done(n);
        check({name, "_latency"}, 64'(n), 64'(NIBBLES));
        check({name, "_s"},       64'(s), 64'(es));
        check({name, "_cout"},    64'(cout), 64'(ec));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_s",    64'(s),    64'(0));
        check("reset_cout", 64'(cout), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, "basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple");
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("ripple_ovf", 64'(ovf), 64'(0));
`endif
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, "cin_only");
        run_op(16'h8888, 16'h7777, 1'b1, 16'h0000, 1'b1, "alt_carry");
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "ovf_pos");
        check("ovf_pos_ovf", 64'(ovf), 64'(1));
`endif

        // Start while busy is ignored.
        wait_idle();
        a = 16'h0003; b = 16'h0004; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("ignore_busy_s", 64'(s), 64'(16'h0007));

        // Start held through DONE: second op accepted back-to-back.
        wait_idle();
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001;
        wait_done(n);
        check("held_first_s", 64'(s), 64'(16'h0003));
        @(negedge clk);
        start = 1'b0;
        check("held_second_busy", 64'(busy), 64'(1));
        wait_done(n);
        check("held_second_latency", 64'(n), 64'(NIBBLES));
        check("held_second_s", 64'(s), 64'(16'h0100));

        // Reset in the middle of an operation.
        wait_idle();
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_s",    64'(s),    64'(0));
        check("midrst_cout", 64'(cout), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            @(negedge clk);
            check("midrst_no_done", 64'(done), 64'(0));
        end
        run_op(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, "post_rst");

        // Randomized traffic, including held starts and one async reset.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            if (i == 300) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
